exc_arbiter_seq: RTL
====================

Name: exc_arbiter_seq

Overview:
Parametrised, registered exception/interrupt arbiter for the MEM/commit boundary of the MIPS pipeline. It synchronises asynchronous hardware interrupt lines and merges in software and timer interrupts. It priority-encodes per-instruction exception flags and captures EPC, BD and BadVAddr. It then drives a flush pulse and holds the report until CP0 acknowledges it.

Parameters:
N_HW_INT, 6, number of hardware interrupt lines (1..6); they map to IP[2+N_HW_INT-1:2] and unused IP bits read 0.
SYNC_STAGES, 2, flip-flop stages on each hardware interrupt line (minimum 2).
ADDR_W, 32, width of PC and bad-address fields.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
hw_int_i  in  N_HW_INT  raw external interrupt levels, asynchronous
sw_int_i  in  2  Cause.IP[1:0] software interrupt bits
timer_int_i  in  1  timer interrupt level, synchronous, ORed into IP7
status_im_i  in  8  Status.IM
status_exl_i  in  1  Status.EXL
status_ie_i  in  1  Status.IE
mem_valid_i  in  1  MEM-stage instruction valid
mem_pc_i  in  ADDR_W  MEM-stage PC
mem_bd_i  in  1  instruction is in a delay slot
mem_exc_i  in  9  flags: [0]AdEL-fetch [1]RI [2]Sys [3]Bp [4]Ov [5]Tr [6]AdEL-data [7]AdES [8]ERET
mem_badaddr_i  in  ADDR_W  faulting address (fetch or data)
cp0_ack_i  in  1  CP0 has consumed the report
cause_ip_o  out  8  synchronised pending IP vector
exc_valid_o  out  1  exception report valid
exc_code_o  out  5  ExcCode
exc_epc_o  out  ADDR_W  EPC to write
exc_bd_o  out  1  BD bit
exc_badvaddr_o  out  ADDR_W  BadVAddr (valid for codes 4/5)
flush_o  out  1  one-cycle pipeline flush
eret_o  out  1  one-cycle ERET commit
busy_o  out  1  arbiter not IDLE; front end must stall

Behaviour:
- Reset: all outputs 0, synchroniser flops 0, FSM in IDLE. Reset asserted mid-report aborts the report without generating an ack.
- cause_ip_o is registered: bits [1:0] = sw_int_i; [2+k] = sync(hw_int_i[k]); bit 7 |= timer_int_i. A hw edge appears after SYNC_STAGES cycles; sw and timer appear after 1 cycle.
- int_req = |(cause_ip_o & status_im_i) & status_ie_i & ~status_exl_i.
- FSM states: IDLE, REPORT.
- IDLE, when mem_valid_i is high and (int_req or any of mem_exc_i[7:0]) is set: capture the report and go to REPORT next cycle. In that cycle exc_valid_o=1 and flush_o=1.
- Priority, highest first: Int 0x00, AdEL-fetch 0x04, RI 0x0A, Sys 0x08, Bp 0x09, Ov 0x0C, Tr 0x0D, AdEL-data 0x04, AdES 0x05.
- Capture: exc_epc_o = mem_bd_i ? mem_pc_i-4 : mem_pc_i, with modulo 2^ADDR_W wrap. exc_bd_o = mem_bd_i. exc_badvaddr_o = mem_badaddr_i only for AdEL/AdES, otherwise it holds its previous value.
- IDLE, when mem_valid_i, mem_exc_i[8] is set, no other flag is set and int_req=0: eret_o=1 and flush_o=1 for one cycle. FSM stays IDLE and no ack is needed. ERET combined with any exception or interrupt is reported as that exception and eret_o stays 0.
- REPORT: exc_valid_o and all captured fields are held stable. flush_o=0 after the first cycle. busy_o=1. mem_* inputs are ignored.
- REPORT, on cp0_ack_i=1: exc_valid_o drops next cycle and FSM returns to IDLE. Evaluation resumes in the cycle after the return to IDLE, not in the ack cycle.
- cp0_ack_i in IDLE is ignored.
- mem_valid_i=0 suppresses all reporting, including interrupts; the interrupt stays pending in cause_ip_o.

Test Plan:
- Reset release, hw_int_i[0] 0→1 at cycle 10, IM=0xFF, IE=1, EXL=0, mem_valid=1, pc=0xBFC00100, bd=0 → cause_ip_o=0x04 at cycle 12; exc_valid_o=1, code 0x00, epc 0xBFC00100 at cycle 13; flush_o high for cycle 13 only.
- mem_exc_i=0x012 (RI+Ov), bd=1, pc=0x80000010 → code 0x0A, epc 0x8000000C, bd=1. Outputs held across 5 cycles without ack; cleared 1 cycle after cp0_ack_i.
- mem_exc_i=0x0C0 (AdEL-data+AdES), badaddr=0x00000003 → code 0x04, badvaddr 0x00000003. Then mem_exc_i=0x010 (Ov, badaddr 0x1234) → code 0x0C, badvaddr still 0x00000003.
- mem_exc_i=0x100 only → eret_o and flush_o high 1 cycle, exc_valid_o=0, busy_o=0. Then mem_exc_i=0x104 → code 0x08 and eret_o=0.
- Timer interrupt with EXL=1 → no report and cause_ip_o[7]=1. Clear EXL → report with code 0x00 next cycle.
- rst_ni pulled low while in REPORT → all outputs 0 immediately. After release, a pending Sys reports normally.

Source files
------------

// File: rtl/exc_arbiter_seq.sv
// Exception/interrupt arbiter at MEM/commit: syncs IRQs, priority-encodes faults, captures EPC/BD/BadVAddr.
// Latency: report/flush/eret registered one cycle after the MEM-stage event; hw IRQs visible in cause_ip_o after SYNC_STAGES.
// Backpressure: report held with busy_o until cp0_ack_i; mem_* ignored while busy.
module exc_arbiter_seq #(
    parameter int N_HW_INT    = 6,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N_HW_INT-1:0] hw_int_i,
    input  logic [1:0]        sw_int_i,
    input  logic              timer_int_i,
    input  logic [7:0]        status_im_i,
    input  logic              status_exl_i,
    input  logic              status_ie_i,
    input  logic              mem_valid_i,
    input  logic [ADDR_W-1:0] mem_pc_i,
    input  logic              mem_bd_i,
    input  logic [8:0]        mem_exc_i,
    input  logic [ADDR_W-1:0] mem_badaddr_i,
    input  logic              cp0_ack_i,
    output logic [7:0]        cause_ip_o,
    output logic              exc_valid_o,
    output logic [4:0]        exc_code_o,
    output logic [ADDR_W-1:0] exc_epc_o,
    output logic              exc_bd_o,
    output logic [ADDR_W-1:0] exc_badvaddr_o,
    output logic              flush_o,
    output logic              eret_o,
    output logic              busy_o
);

    typedef enum logic {IDLE, REPORT} state_t;

    state_t                                 state_q, state_d;
    logic [SYNC_STAGES-1:0][N_HW_INT-1:0]   sync_q;
    logic [1:0]                             sw_q;
    logic                                   timer_q;
    logic [5:0]                             hw_ip;
    logic                                   int_req;
    logic                                   any_exc;
    logic                                   take;
    logic                                   do_eret;
    logic                                   addr_exc;
    logic [4:0]                             code_d;
    logic [ADDR_W-1:0]                      epc_d;
    logic                                   flush_q, eret_q, bd_q;
    logic [4:0]                             code_q;
    logic [ADDR_W-1:0]                      epc_q, badvaddr_q;

    // The last synchroniser stage is itself the registered IP bit, so a hw edge costs exactly SYNC_STAGES cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            sw_q    <= '0;
            timer_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], hw_int_i};
            sw_q    <= sw_int_i;
            timer_q <= timer_int_i;
        end
    end

    always_comb begin
        hw_ip = '0;
        hw_ip[N_HW_INT-1:0] = sync_q[SYNC_STAGES-1];
    end

    assign cause_ip_o = {hw_ip[5] | timer_q, hw_ip[4:0], sw_q};
    assign int_req    = (|(cause_ip_o & status_im_i)) & status_ie_i & ~status_exl_i;
    assign any_exc    = |mem_exc_i[7:0];
    assign take       = (state_q == IDLE) && mem_valid_i && (int_req || any_exc);
    assign do_eret    = (state_q == IDLE) && mem_valid_i && mem_exc_i[8] && !any_exc && !int_req;
    assign epc_d      = mem_bd_i ? mem_pc_i - ADDR_W'(4) : mem_pc_i;

    always_comb begin
        code_d   = 5'h00;
        addr_exc = 1'b0;
        if (int_req)           code_d = 5'h00;
        else if (mem_exc_i[0]) begin code_d = 5'h04; addr_exc = 1'b1; end
        else if (mem_exc_i[1]) code_d = 5'h0A;
        else if (mem_exc_i[2]) code_d = 5'h08;
        else if (mem_exc_i[3]) code_d = 5'h09;
        else if (mem_exc_i[4]) code_d = 5'h0C;
        else if (mem_exc_i[5]) code_d = 5'h0D;
        else if (mem_exc_i[6]) begin code_d = 5'h04; addr_exc = 1'b1; end
        else if (mem_exc_i[7]) begin code_d = 5'h05; addr_exc = 1'b1; end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = REPORT;
            REPORT:  if (cp0_ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            flush_q    <= 1'b0;
            eret_q     <= 1'b0;
            code_q     <= '0;
            epc_q      <= '0;
            bd_q       <= 1'b0;
            badvaddr_q <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= take | do_eret;
            eret_q  <= do_eret;
            if (take) begin
                code_q <= code_d;
                epc_q  <= epc_d;
                bd_q   <= mem_bd_i;
                if (addr_exc) badvaddr_q <= mem_badaddr_i;
            end else if (state_q == REPORT && cp0_ack_i) begin
                // BadVAddr deliberately survives the ack; only the per-report fields are cleared.
                code_q <= '0;
                epc_q  <= '0;
                bd_q   <= 1'b0;
            end
        end
    end

    assign exc_valid_o    = (state_q == REPORT);
    assign busy_o         = (state_q == REPORT);
    assign flush_o        = flush_q;
    assign eret_o         = eret_q;
    assign exc_code_o     = code_q;
    assign exc_epc_o      = epc_q;
    assign exc_bd_o       = bd_q;
    assign exc_badvaddr_o = badvaddr_q;

endmodule
